// File: rtl/tank_input_decoder_if.sv
// ============================================================================
// Module   : tank_input_decoder_if
// Brief    : Keycode, frame-tick and per-player fire handshake bundle between
//            the SoC/game logic and the tank input decoder.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface tank_input_decoder_if;
  logic [31:0] keycode;
  logic        frame_tick;
  logic [3:0]  p1_dir;
  logic [3:0]  p2_dir;
  logic        p1_fire_req;
  logic        p2_fire_req;
  logic        p1_fire_ack;
  logic        p2_fire_ack;

  modport master (
    output keycode,
    output frame_tick,
    output p1_fire_ack,
    output p2_fire_ack,
    input  p1_dir,
    input  p2_dir,
    input  p1_fire_req,
    input  p2_fire_req
  );

  modport slave (
    input  keycode,
    input  frame_tick,
    input  p1_fire_ack,
    input  p2_fire_ack,
    output p1_dir,
    output p2_dir,
    output p1_fire_req,
    output p2_fire_req
  );
endinterface

`default_nettype wire

// File: rtl/tank_input_decoder.sv
// ============================================================================
// Module   : tank_input_decoder
// Brief    : HID keycode word -> debounced two-player tank directions and
//            fire request/ack handshakes with frame-based cooldown.
//            Optional macro TANK_ROLLOVER_GUARD_EN freezes the controls while
//            any keycode byte reports HID ErrorRollOver (0x01).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tank_input_decoder #(
  parameter int STABLE_CYCLES   = 16,
  parameter int COOLDOWN_FRAMES = 30,
  parameter int CNT_W           = 8
) (
  input wire                  Clk,
  input wire                  Reset,
  tank_input_decoder_if.slave bus
);

  // Key vector layout per player (base p*5): +0 up, +1 down, +2 left,
  // +3 right, +4 fire. Player 1 occupies [4:0], player 2 occupies [9:5].
  localparam int              c_num_keys    = 10;
  localparam logic [79:0]     c_key_codes   = {8'h28, 8'h4F, 8'h50, 8'h51, 8'h52,
                                               8'h2C, 8'h07, 8'h04, 8'h16, 8'h1A};
  localparam logic [CNT_W-1:0] c_stable_last = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] c_cool_load   = CNT_W'(COOLDOWN_FRAMES);
  localparam logic [CNT_W-1:0] c_cnt_max     = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_COOL = 2'd2
  } fire_state_t;

  logic [c_num_keys-1:0] w_raw_next;
  logic [c_num_keys-1:0] w_raw_load;
  logic [c_num_keys-1:0] r_raw;
  logic [c_num_keys-1:0] r_filt;
  logic [1:0]            r_fire_prev;
  logic [CNT_W-1:0]      r_stab_cnt;
  logic [3:0]            r_p1_dir;
  logic [3:0]            r_p2_dir;
  logic [1:0]            w_fire_req;

  // Opposing keys cancel each other; output order is {up,down,left,right}.
  function automatic logic [3:0] resolve_dir(input logic [3:0] k);
    logic u, d, l, r;
    u = k[0] & ~k[1];
    d = k[1] & ~k[0];
    l = k[2] & ~k[3];
    r = k[3] & ~k[2];
    return {u, d, l, r};
  endfunction

  always_comb begin
    w_raw_next = '0;
    for (int k = 0; k < c_num_keys; k++) begin
      for (int b = 0; b < 4; b++) begin
        if (bus.keycode[b*8 +: 8] == c_key_codes[k*8 +: 8]) begin
          w_raw_next[k] = 1'b1;
        end
      end
    end
  end

`ifdef TANK_ROLLOVER_GUARD_EN
  logic w_rollover;

  always_comb begin
    w_rollover = 1'b0;
    for (int b = 0; b < 4; b++) begin
      if (bus.keycode[b*8 +: 8] == 8'h01) begin
        w_rollover = 1'b1;
      end
    end
  end

  // Holding the raw vector also keeps the stability counter from clearing.
  assign w_raw_load = w_rollover ? r_raw : w_raw_next;
`else
  assign w_raw_load = w_raw_next;
`endif

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_raw       <= '0;
      r_stab_cnt  <= '0;
      r_filt      <= '0;
      r_fire_prev <= '0;
    end else begin
      r_raw <= w_raw_load;
      if (w_raw_load != r_raw) begin
        r_stab_cnt <= '0;
      end else if (r_stab_cnt != c_cnt_max) begin
        r_stab_cnt <= r_stab_cnt + 1'b1;
      end
      if (r_stab_cnt == c_stable_last) begin
        r_filt <= r_raw;
      end
      r_fire_prev <= {r_filt[9], r_filt[4]};
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_p1_dir <= '0;
      r_p2_dir <= '0;
    end else if (bus.frame_tick) begin
      r_p1_dir <= resolve_dir(r_filt[3:0]);
      r_p2_dir <= resolve_dir(r_filt[8:5]);
    end
  end

  for (genvar p = 0; p < 2; p++) begin : g_fire
    fire_state_t      r_state;
    fire_state_t      w_state_next;
    logic [CNT_W-1:0] r_cool;
    logic [CNT_W-1:0] w_cool_next;
    logic             w_edge;
    logic             w_ack;

    assign w_edge = r_filt[p*5+4] & ~r_fire_prev[p];
    assign w_ack  = (p == 0) ? bus.p1_fire_ack : bus.p2_fire_ack;

    always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
        r_state <= S_IDLE;
        r_cool  <= '0;
      end else begin
        r_state <= w_state_next;
        r_cool  <= w_cool_next;
      end
    end

    // Edges seen in REQ/COOL fall through unused: presses are never queued.
    always_comb begin
      w_state_next = r_state;
      w_cool_next  = r_cool;
      case (r_state)
        S_IDLE: begin
          if (w_edge) begin
            w_state_next = S_REQ;
          end
        end
        S_REQ: begin
          if (w_ack) begin
            if (COOLDOWN_FRAMES == 0) begin
              w_state_next = S_IDLE;
            end else begin
              w_state_next = S_COOL;
              w_cool_next  = c_cool_load;
            end
          end
        end
        S_COOL: begin
          if (r_cool == '0) begin
            w_state_next = S_IDLE;
          end else if (bus.frame_tick) begin
            w_cool_next = r_cool - 1'b1;
            if (r_cool == CNT_W'(1)) begin
              w_state_next = S_IDLE;
            end
          end
        end
        default: begin
          w_state_next = S_IDLE;
          w_cool_next  = '0;
        end
      endcase
    end

    assign w_fire_req[p] = (r_state == S_REQ);
  end

  assign bus.p1_dir      = r_p1_dir;
  assign bus.p2_dir      = r_p2_dir;
  assign bus.p1_fire_req = w_fire_req[0];
  assign bus.p2_fire_req = w_fire_req[1];

endmodule

`default_nettype wire

// File: doc/tank_input_decoder.md
Name: tank_input_decoder

Overview:
- Consumes the 32-bit `keycode` word from the SoC's keycode PIO. It carries four USB HID keycodes, byte 0 = keycode[7:0], and 0x00 means an empty slot.
- Produces debounced, per-frame tank controls for two players: a movement direction, plus a fire request with a handshake and a cooldown.
- Sits between the SoC and the tank/bullet game logic. Frame timing comes from the VGA controller's per-frame tick.

Parameters:
- STABLE_CYCLES, 16: consecutive cycles a raw key vector must stay unchanged before the filtered vector accepts it.
- COOLDOWN_FRAMES, 30: frames a player must wait after a fire acknowledge before firing again.
- CNT_W, 8: width of the stability counter and the cooldown counters. It must be able to hold both STABLE_CYCLES and COOLDOWN_FRAMES.

Ports:
- Clk  in  1  system clock, rising edge.
- Reset  in  1  asynchronous, active-high reset.
- keycode  in  32  four HID keycodes from the SoC keycode PIO.
- frame_tick  in  1  one-cycle pulse per video frame, taken from the VGA vsync edge.
- p1_dir  out  4  player 1 direction {up,down,left,right}, updated on frame_tick.
- p2_dir  out  4  player 2 direction {up,down,left,right}, updated on frame_tick.
- p1_fire_req  out  1  player 1 fire request, level; held until acknowledged.
- p2_fire_req  out  1  player 2 fire request, level; held until acknowledged.
- p1_fire_ack  in  1  game logic has spawned player 1's bullet.
- p2_fire_ack  in  1  game logic has spawned player 2's bullet.

Behaviour:
- Key map:
  - Player 1: W=0x1A up, S=0x16 down, A=0x04 left, D=0x07 right, Space=0x2C fire.
  - Player 2: Up=0x52, Down=0x51, Left=0x50, Right=0x4F, Enter=0x28 fire.
  - A key is pressed when any of the 4 bytes equals its code. 0x00 bytes and unmapped codes are ignored.
- Raw vector: the 10 key-pressed bits are registered once, giving 1 cycle of latency.
- Stability filter:
  - The counter clears whenever the raw vector differs from its previous-cycle value, and otherwise increments, saturating.
  - When the counter reaches STABLE_CYCLES-1, the filtered vector is loaded from the raw vector.
  - A change is therefore visible STABLE_CYCLES+1 cycles after the keycode changes.
- Direction outputs:
  - p1_dir and p2_dir load from the filtered vector only in a cycle where frame_tick=1; between ticks they hold.
  - Opposing keys cancel: if up and down are both pressed, both output 0. Left with right behaves the same way.
- Fire FSM, one per player, states IDLE, REQ, COOL:
  - Fire edge = filtered fire bit is 1 now and was 0 in the previous cycle. It is detected in every state.
  - IDLE: on a fire edge, go to REQ. fire_req=1 from the next cycle.
  - REQ: fire_req holds 1 until fire_ack=1. Then, on the next cycle, fire_req=0 and the cooldown counter loads COOLDOWN_FRAMES. If COOLDOWN_FRAMES=0, go directly to IDLE.
  - COOL: the counter decrements on each frame_tick. When it decrements to 0, go to IDLE.
  - Edges in REQ or COOL are discarded, not queued: a held key never re-fires, and the player must release and re-press.
  - fire_ack outside REQ is ignored.
  - An edge and an ack in the same cycle while in REQ: the ack wins and the edge is discarded.
- Reset, asserted at any time including mid-request or mid-cooldown:
  - All outputs 0, FSMs in IDLE, all counters 0.
  - Raw and filtered vectors 0; held keys then re-qualify through the filter.
  - No fire edge is generated for a key already held at reset release until the filter passes it: it produces a 0→1 edge and is treated as a new press.
- Arithmetic: counters are unsigned CNT_W and never wrap. Stability saturates at its maximum; cooldown stops at 0.

Optional Feature:
- Macro: TANK_ROLLOVER_GUARD_EN.
- Defined: if any byte equals 0x01 (HID ErrorRollOver), the raw-vector register holds its previous value for that cycle and the stability counter is not cleared, so the controls freeze. Normal updates resume once no byte is 0x01.
- Undefined: 0x01 is treated as an ordinary unmapped code.

Test Plan:
- Reset, then keycode=0x0000001A held for 20 cycles, then frame_tick → p1_dir=4'b1000 after that tick; p2_dir=0; p1_dir stays 0 before the first tick.
- keycode toggles between 0x1A and 0x00 every 5 cycles with STABLE_CYCLES=16 → filtered vector never changes; p1_dir stays 0 across ticks.
- keycode=0x00161A00 (W and S) held, then frame_tick → p1_dir=4'b0000.
- keycode=0x0000002C held → p1_fire_req rises once. Ack 3 cycles later → req=0 the next cycle. With the key held through 40 frame ticks, no second request.
- Release, press Space 10 frames after the ack (cooldown=30) → no request. Release, press again after 31 frames → request.
- Reset asserted while p2 is in REQ → p2_fire_req=0 asynchronously. After release with Enter held, exactly one new request after the filter delay.
